// File: rtl/store_buffer.sv
// In-order store queue between the core store port and the data-memory write port.
// Optional store-to-load forwarding is built only when STORE_BUF_FWD_EN is defined.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemWrite,
   input  logic [AW-1:0]     DataAdr,
   input  logic [DW-1:0]     WriteData,
   input  logic [DW/8-1:0]   MemWriteSelect,
   output logic              StoreStall,
   output logic              BufEmpty,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   output logic [DW/8-1:0]   mem_be,
   input  logic [AW-1:0]     ReadAdr,
   output logic              fwd_hit,
   output logic [DW-1:0]     fwd_data,
   output logic [DW/8-1:0]   fwd_be
);
   localparam int PW = $clog2(DEPTH);
   localparam int BW = DW / 8;

   // Entries hold word addresses only; byte offset is never needed downstream.
   logic [AW-3:0] addr_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [BW-1:0] be_q   [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          full, empty, push, pop;

   assign full  = (count_q == (PW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = MemWrite && (|MemWriteSelect) && !full;
   assign pop   = !empty && mem_ready;

   assign StoreStall = MemWrite && full;
   assign BufEmpty   = empty;
   assign mem_valid  = !empty;
   assign mem_addr   = empty ? '0 : {addr_q[rd_ptr_q], 2'b00};
   assign mem_wdata  = empty ? '0 : data_q[rd_ptr_q];
   assign mem_be     = empty ? '0 : be_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
            be_q[i]   <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push) begin
            addr_q[wr_ptr_q] <= DataAdr[AW-1:2];
            data_q[wr_ptr_q] <= WriteData;
            be_q[wr_ptr_q]   <= MemWriteSelect;
         end
      end
   end

`ifdef STORE_BUF_FWD_EN
   logic unused_lo;
   assign unused_lo = ^{DataAdr[1:0], ReadAdr[1:0]};

   // Scan oldest to youngest so the youngest matching entry overrides older ones.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_be   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (((PW+1)'(i) < count_q) &&
             (addr_q[rd_ptr_q + PW'(i)] == ReadAdr[AW-1:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[rd_ptr_q + PW'(i)];
            fwd_be   = be_q[rd_ptr_q + PW'(i)];
         end
      end
   end
`else
   logic unused_lo;
   assign unused_lo = ^{DataAdr[1:0], ReadAdr};
   assign fwd_hit   = 1'b0;
   assign fwd_data  = '0;
   assign fwd_be    = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table, reset/forwarding sequences,
// and randomized traffic against a queue-based reference model.
module tb_store_buffer;
   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite;
   logic [31:0] DataAdr, WriteData, ReadAdr;
   logic [3:0]  MemWriteSelect;
   logic        StoreStall, BufEmpty, mem_valid, mem_ready;
   logic [31:0] mem_addr, mem_wdata, fwd_data;
   logic [3:0]  mem_be, fwd_be;
   logic        fwd_hit;

   int nchk  = 0;
   int npass = 0;

   store_buffer dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
      .WriteData(WriteData), .MemWriteSelect(MemWriteSelect),
      .StoreStall(StoreStall), .BufEmpty(BufEmpty), .mem_valid(mem_valid),
      .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .ReadAdr(ReadAdr), .fwd_hit(fwd_hit),
      .fwd_data(fwd_data), .fwd_be(fwd_be)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic mw; logic [31:0] adr; logic [31:0] wd; logic [3:0] be; logic rdy;
      logic ev; logic [31:0] ea; logic [31:0] ed; logic [3:0] eb; logic es; logic ee;
   } vec_t;

   typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] b; } ent_t;

   vec_t tv[$];
   ent_t q[$];

   function automatic vec_t mk(logic mw, logic [31:0] adr, logic [31:0] wd, logic [3:0] be,
                               logic rdy, logic ev, logic [31:0] ea, logic [31:0] ed,
                               logic [3:0] eb, logic es, logic ee);
      vec_t v;
      v.mw = mw; v.adr = adr; v.wd = wd; v.be = be; v.rdy = rdy;
      v.ev = ev; v.ea = ea; v.ed = ed; v.eb = eb; v.es = es; v.ee = ee;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic r, input logic [31:0] ra);
      MemWrite = mw; DataAdr = a; WriteData = d; MemWriteSelect = b;
      mem_ready = r; ReadAdr = ra;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_head(input string nm, input logic ev, input logic [31:0] ea,
                           input logic [31:0] ed, input logic [3:0] eb,
                           input logic es, input logic ee);
      chk({nm, ".valid"}, 64'(mem_valid), 64'(ev));
      chk({nm, ".addr"},  64'(mem_addr),  64'(ea));
      chk({nm, ".wdata"}, 64'(mem_wdata), 64'(ed));
      chk({nm, ".be"},    64'(mem_be),    64'(eb));
      chk({nm, ".stall"}, 64'(StoreStall), 64'(es));
      chk({nm, ".empty"}, 64'(BufEmpty),  64'(ee));
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
      #12;
      chk_head("in_reset", 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
      chk("in_reset.fwd_hit", 64'(fwd_hit), 64'h0);
      #10 reset = 1'b0;
      tick();

      // Directed vectors: inputs applied for one cycle, outputs checked mid-cycle.
      tv.push_back(mk(0, 0,     0,     4'h0, 0, 0, 0,     0,     4'h0, 0, 1));
      tv.push_back(mk(1, 100,   25,    4'hF, 1, 0, 0,     0,     4'h0, 0, 1));
      tv.push_back(mk(0, 0,     0,     4'h0, 1, 1, 100,   25,    4'hF, 0, 0));
      tv.push_back(mk(0, 0,     0,     4'h0, 0, 0, 0,     0,     4'h0, 0, 1));
      tv.push_back(mk(1, 0,     'hA0,  4'hF, 0, 0, 0,     0,     4'h0, 0, 1));
      tv.push_back(mk(1, 4,     'hA1,  4'hF, 0, 1, 0,     'hA0,  4'hF, 0, 0));
      tv.push_back(mk(1, 8,     'hA2,  4'hF, 0, 1, 0,     'hA0,  4'hF, 0, 0));
      tv.push_back(mk(1, 12,    'hA3,  4'hF, 0, 1, 0,     'hA0,  4'hF, 0, 0));
      tv.push_back(mk(1, 16,    'hA4,  4'hF, 0, 1, 0,     'hA0,  4'hF, 1, 0));
      tv.push_back(mk(1, 16,    'hA4,  4'hF, 0, 1, 0,     'hA0,  4'hF, 1, 0));
      tv.push_back(mk(1, 16,    'hA4,  4'hF, 1, 1, 0,     'hA0,  4'hF, 1, 0));
      tv.push_back(mk(1, 16,    'hA4,  4'hF, 1, 1, 4,     'hA1,  4'hF, 0, 0));
      tv.push_back(mk(0, 0,     0,     4'h0, 1, 1, 8,     'hA2,  4'hF, 0, 0));
      tv.push_back(mk(0, 0,     0,     4'h0, 1, 1, 12,    'hA3,  4'hF, 0, 0));
      tv.push_back(mk(0, 0,     0,     4'h0, 1, 1, 16,    'hA4,  4'hF, 0, 0));
      tv.push_back(mk(0, 0,     0,     4'h0, 1, 0, 0,     0,     4'h0, 0, 1));
      tv.push_back(mk(1, 'h200, 'hB0,  4'hF, 0, 0, 0,     0,     4'h0, 0, 1));
      tv.push_back(mk(1, 'h204, 'hB1,  4'h3, 0, 1, 'h200, 'hB0,  4'hF, 0, 0));
      tv.push_back(mk(1, 'h208, 'hB2,  4'hC, 1, 1, 'h200, 'hB0,  4'hF, 0, 0));
      tv.push_back(mk(1, 'h20C, 'hB3,  4'h1, 1, 1, 'h204, 'hB1,  4'h3, 0, 0));
      tv.push_back(mk(0, 0,     0,     4'h0, 1, 1, 'h208, 'hB2,  4'hC, 0, 0));
      tv.push_back(mk(0, 0,     0,     4'h0, 1, 1, 'h20C, 'hB3,  4'h1, 0, 0));
      tv.push_back(mk(0, 0,     0,     4'h0, 1, 0, 0,     0,     4'h0, 0, 1));
      tv.push_back(mk(1, 'h300, 'hEE,  4'h0, 0, 0, 0,     0,     4'h0, 0, 1));
      tv.push_back(mk(0, 0,     0,     4'h0, 1, 0, 0,     0,     4'h0, 0, 1));
      tv.push_back(mk(1, 'h103, 'hC,   4'h2, 0, 0, 0,     0,     4'h0, 0, 1));
      tv.push_back(mk(0, 0,     0,     4'h0, 1, 1, 'h100, 'hC,   4'h2, 0, 0));
      tv.push_back(mk(0, 0,     0,     4'h0, 0, 0, 0,     0,     4'h0, 0, 1));

      foreach (tv[i]) begin
         drive(tv[i].mw, tv[i].adr, tv[i].wd, tv[i].be, tv[i].rdy, 32'h0);
         #3;
         chk_head($sformatf("vec%0d", i), tv[i].ev, tv[i].ea, tv[i].ed, tv[i].eb,
                  tv[i].es, tv[i].ee);
         tick();
      end

      // Forwarding: two stores to the same word, youngest must win.
      drive(1'b1, 96, 11, 4'h1, 1'b0, 32'h0); tick();
      drive(1'b1, 96, 22, 4'h3, 1'b0, 32'h0); tick();
      drive(1'b0, 0, 0, 4'h0, 1'b0, 98); #3;
`ifdef STORE_BUF_FWD_EN
      chk("fwd98.hit",  64'(fwd_hit),  64'h1);
      chk("fwd98.data", 64'(fwd_data), 64'd22);
      chk("fwd98.be",   64'(fwd_be),   64'h3);
`else
      chk("fwd98.hit",  64'(fwd_hit),  64'h0);
      chk("fwd98.data", 64'(fwd_data), 64'h0);
      chk("fwd98.be",   64'(fwd_be),   64'h0);
`endif
      ReadAdr = 200; #1;
      chk("fwd200.hit", 64'(fwd_hit), 64'h0);
      tick();
      drive(1'b0, 0, 0, 4'h0, 1'b1, 32'h0);
      tick(); tick(); #1;
      chk("fwd_drain.empty", 64'(BufEmpty), 64'h1);
      tick();

      // Asynchronous reset with three stores pending.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h40 + 32'(i*4), 32'h70 + 32'(i), 4'hF, 1'b0, 32'h40);
         tick();
      end
      drive(1'b0, 0, 0, 4'h0, 1'b1, 32'h40); #2;
      chk("pre_rst.valid", 64'(mem_valid), 64'h1);
      reset = 1'b1; #1;
      chk_head("async_rst", 1'b0, 0, 0, 4'h0, 1'b0, 1'b1);
      chk("async_rst.fwd_hit", 64'(fwd_hit), 64'h0);
      tick();
      reset = 1'b0;
      tick();
      chk_head("post_rst", 1'b0, 0, 0, 4'h0, 1'b0, 1'b1);
      drive(1'b1, 32'h400, 32'hDD, 4'hF, 1'b0, 32'h0); tick();
      drive(1'b0, 0, 0, 4'h0, 1'b1, 32'h0); #3;
      chk_head("post_rst_st", 1'b1, 32'h400, 32'hDD, 4'hF, 1'b0, 1'b0);
      tick(); #3;
      chk_head("post_rst_drained", 1'b0, 0, 0, 4'h0, 1'b0, 1'b1);
      tick();

      // Randomized traffic against the queue model.
      q.delete();
      for (int cyc = 0; cyc < 400; cyc++) begin
         logic        mw, rdy, ehit;
         logic [31:0] a, d, ra, efd;
         logic [3:0]  b, efb;
         ent_t        e;
         mw  = ($urandom_range(0, 9) < 7);
         a   = {26'h0, 4'($urandom_range(0, 7)), 2'($urandom)};
         d   = $urandom;
         b   = 4'($urandom_range(0, 15));
         rdy = ($urandom_range(0, 1) == 1);
         ra  = {26'h0, 4'($urandom_range(0, 7)), 2'($urandom)};
         drive(mw, a, d, b, rdy, ra);
         #3;
         if (q.size() != 0)
            chk_head("rnd", 1'b1, {q[0].a[31:2], 2'b00}, q[0].d, q[0].b,
                     mw && (q.size() == 4), 1'b0);
         else
            chk_head("rnd", 1'b0, 0, 0, 4'h0, 1'b0, 1'b1);
         ehit = 1'b0; efd = 0; efb = 0;
`ifdef STORE_BUF_FWD_EN
         for (int k = q.size() - 1; k >= 0; k--) begin
            if (q[k].a[31:2] == ra[31:2]) begin
               ehit = 1'b1; efd = q[k].d; efb = q[k].b;
               break;
            end
         end
`endif
         chk("rnd.fwd_hit",  64'(fwd_hit),  64'(ehit));
         chk("rnd.fwd_data", 64'(fwd_data), 64'(efd));
         chk("rnd.fwd_be",   64'(fwd_be),   64'(efb));
         e.a = a; e.d = d; e.b = b;
         if (mw && b != 0 && q.size() < 4) begin
            if (q.size() != 0 && rdy) void'(q.pop_front());
            q.push_back(e);
         end else if (q.size() != 0 && rdy) begin
            void'(q.pop_front());
         end
         tick();
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
